// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bit positions, datapath widths and
// the memory-stage FSM encoding.
package pipe_pkg;

   localparam int DATA_W      = 32;
   localparam int REG_W       = 5;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;
   localparam int MEM_READ    = 1;
   localparam int MEM_WRITE   = 0;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } memState_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage bundled as one bus;
// the upstream pipeline is the master, mem_stage is the slave.
interface mem_stage_if;
   import pipe_pkg::*;

   logic [1:0]        wb_in;
   logic [1:0]        mem_in;
   logic [DATA_W-1:0] result_in;
   logic [DATA_W-1:0] rb_in;
   logic [REG_W-1:0]  reg_dst_in;
   logic              stall;
   logic [1:0]        wb_out;
   logic [DATA_W-1:0] rd_data_out;
   logic [DATA_W-1:0] result_out;
   logic [REG_W-1:0]  reg_dst_out;

   modport master (
      output wb_in, mem_in, result_in, rb_in, reg_dst_in,
      input  stall, wb_out, rd_data_out, result_out, reg_dst_out
   );

   modport slave (
      input  wb_in, mem_in, result_in, rb_in, reg_dst_in,
      output stall, wb_out, rd_data_out, result_out, reg_dst_out
   );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: synchronous write, combinational read.
// Contents are deliberately not reset.
module data_mem
   import pipe_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [DATA_W-1:0]        i_wdata,
   output logic [DATA_W-1:0]        o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: performs loads/stores with LAT-cycle occupancy, stalls the
// upstream stages meanwhile and feeds the MEM/WB pipeline register.
module mem_stage
   import pipe_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int LAT   = 1
) (
   input logic        clk,
   input logic        rst,
   mem_stage_if.slave bus
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [3:0]  CNT_INIT = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;

   memState_t         r_state;
   memState_t         w_stateNext;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cntNext;
   logic              w_stallRaw;
   logic              w_complete;
   logic              w_access;
   logic              w_isWrite;
   logic              w_isRead;
   logic              w_stall;
   logic              w_we;
   logic [AW-1:0]     w_idx;
   logic [DATA_W-1:0] w_rdata;
   logic              w_unusedAddrBits;

   logic [1:0]        r_wbOut;
   logic [DATA_W-1:0] r_rdDataOut;
   logic [DATA_W-1:0] r_resultOut;
   logic [REG_W-1:0]  r_regDstOut;

   // Low two bits select a byte and high bits wrap, so only the word index matters.
   assign w_idx            = bus.result_in[AW+1:2];
   assign w_unusedAddrBits = ^{bus.result_in[DATA_W-1:AW+2], bus.result_in[1:0]};

   // The illegal read+write encoding behaves as a plain store.
   assign w_access  = |bus.mem_in;
   assign w_isWrite = bus.mem_in[MEM_WRITE];
   assign w_isRead  = bus.mem_in[MEM_READ] & ~bus.mem_in[MEM_WRITE];

   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_stallRaw  = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_access) begin
               if (LAT == 1) begin
                  w_complete = 1'b1;
               end else begin
                  w_stallRaw  = 1'b1;
                  w_cntNext   = CNT_INIT;
                  w_stateNext = BUSY;
               end
            end
         end
         BUSY: begin
            if (r_cnt != 4'd0) begin
               w_stallRaw = 1'b1;
               w_cntNext  = r_cnt - 4'd1;
            end else begin
               w_complete  = 1'b1;
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Gating with rst keeps an aborted access from stalling or committing.
   assign w_stall   = w_stallRaw & ~rst;
   assign w_we      = w_complete & w_isWrite & ~rst;
   assign bus.stall = w_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
      end
   end

   data_mem #(.DEPTH(DEPTH)) u_dataMem (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_idx),
      .i_wdata (bus.rb_in),
      .o_rdata (w_rdata)
   );

   // MEM/WB register; stall cycles insert a bubble so no stale RegWrite escapes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wbOut     <= 2'b00;
         r_rdDataOut <= '0;
         r_resultOut <= '0;
         r_regDstOut <= '0;
      end else if (w_stall) begin
         r_wbOut     <= 2'b00;
         r_rdDataOut <= '0;
         r_resultOut <= '0;
         r_regDstOut <= '0;
      end else begin
         r_wbOut     <= bus.wb_in;
         r_rdDataOut <= w_isRead ? w_rdata : '0;
         r_resultOut <= bus.result_in;
         r_regDstOut <= bus.reg_dst_in;
      end
   end

   assign bus.wb_out      = r_wbOut;
   assign bus.rd_data_out = r_rdDataOut;
   assign bus.result_out  = r_resultOut;
   assign bus.reg_dst_out = r_regDstOut;

endmodule
